pool_seq_ctrl: RTL
==================

POOL_SEQ_CTRL -- requirements
Module: pool_seq_ctrl

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 8: sample and result width.
REQ-002 The block SHALL have parameter LENGTH, default 4: samples per pooling window.
REQ-003 The block SHALL have parameter POOL_LAT, default 1: drain beats between the last window sample and a valid datapath result.
REQ-004 The block SHALL have parameter CNT_W, default 16: width of the window count.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1 bit: pulse that begins a frame.
REQ-008 The block SHALL have port num_windows, input, CNT_W bits: windows per frame, sampled on an accepted start.
REQ-009 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, BITWIDTH): unsigned sample stream.
REQ-010 The block SHALL have ports pool_ena (output, 1) and pool_data (output, BITWIDTH): shift-enable and data to the pooling datapath.
REQ-011 The block SHALL have port pool_result, input, BITWIDTH bits: unsigned max from the pooling datapath.
REQ-012 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, BITWIDTH): pooled result stream.
REQ-013 The block SHALL have ports busy (output, 1) and done (output, 1): frame active, and a one-cycle end-of-frame pulse.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, DRAIN, OUT and FIN.
REQ-015 IDLE: on start=1, the block SHALL latch num_windows, clear the window and sample counters, and go to LOAD, or to FIN if num_windows=0.
REQ-016 A start pulse in any state other than IDLE SHALL be ignored.
REQ-017 in_ready SHALL be 1 only in LOAD, and be combinational from state.
REQ-018 LOAD: pool_ena SHALL equal in_valid and in_ready together, and pool_data SHALL equal in_data, so a stall produces no shift.
REQ-019 The sample counter SHALL count accepted beats 0..LENGTH-1; the LENGTH-th beat SHALL wrap it to 0 and move the FSM to DRAIN.
REQ-020 DRAIN: the block SHALL assert pool_ena=1 with pool_data=0 for exactly POOL_LAT cycles, then go to OUT.
REQ-021 On entry to OUT, the block SHALL register pool_result into out_data, with out_data stable for the whole time out_valid=1.
REQ-022 out_valid SHALL rise POOL_LAT+1 clock edges after the edge that accepted the last window sample.
REQ-023 OUT: out_valid SHALL stay 1 until out_valid and out_ready are both 1; pool_ena SHALL be 0 throughout.
REQ-024 On the OUT handshake edge, the window counter SHALL increment; the FSM SHALL go to FIN if the counter then equals the latched count, else to LOAD.
REQ-025 out_valid SHALL be 0 in the cycle after the handshake, so there is no back-to-back result.
REQ-026 FIN: done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-027 busy SHALL be 1 in LOAD, DRAIN, OUT and FIN, and 0 in IDLE.
REQ-028 Counters SHALL be unsigned; the window count SHALL compare at full CNT_W width; num_windows changes after start SHALL have no effect.
REQ-029 If in_valid=1 outside LOAD, the sample SHALL NOT be consumed and SHALL NOT cause a shift.

Reset
REQ-030 While rst=1, asynchronously: state SHALL be IDLE, all counters 0, out_data 0, and out_valid, in_ready, pool_ena, pool_data, busy and done all 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no done pulse; the first frame after reset release SHALL require a new start.

Structure
REQ-032 A shared package pool_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-033 No sub-module SHALL be used; the datapath SHALL remain a separate instance wired alongside this block by the parent.

Verification
REQ-034 The bench SHALL check: LENGTH=4, num_windows=1, samples 3,9,2,7 with no stalls -> 4 pool_ena beats, 1 drain beat, out_data=9, one done pulse.
REQ-035 The bench SHALL check: in_valid dropped for 3 cycles between samples 2 and 3 -> pool_ena=0 during the gap, result unchanged (9).
REQ-036 The bench SHALL check: num_windows=2, out_ready held 0 for 5 cycles -> out_valid and out_data held, in_ready=0, second window starts the cycle after the handshake.
REQ-037 The bench SHALL check: start with num_windows=0 -> busy=1 for 1 cycle, done pulse, zero pool_ena beats.
REQ-038 The bench SHALL check: rst asserted after 2 samples -> all outputs 0 immediately, no done; a new start then produces a correct full window.
REQ-039 The bench SHALL check: start pulsed during LOAD -> ignored, frame count unchanged.

Source files
------------

// File: rtl/pool_pkg.sv
// ============================================================================
// pool_pkg : shared FSM state encoding and default parameters for pool_seq_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package pool_pkg;

  localparam int POOL_BITWIDTH = 8;
  localparam int POOL_LENGTH   = 4;
  localparam int POOL_LAT_DEF  = 1;
  localparam int POOL_CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_FIN   = 3'd4
  } pool_state_t;

endpackage

`default_nettype wire

// File: rtl/pool_seq_ctrl.sv
// ============================================================================
// pool_seq_ctrl : sequences sample windows into an external max-pool datapath
// Rev 1.0
// ============================================================================
`default_nettype none

module pool_seq_ctrl
  import pool_pkg::*;
#(
  parameter int BITWIDTH = POOL_BITWIDTH,
  parameter int LENGTH   = POOL_LENGTH,
  parameter int POOL_LAT = POOL_LAT_DEF,   // must be >= 1
  parameter int CNT_W    = POOL_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-1:0]    num_windows,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  output logic                pool_ena,
  output logic [BITWIDTH-1:0] pool_data,
  input  logic [BITWIDTH-1:0] pool_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BITWIDTH-1:0] out_data,
  output logic                busy,
  output logic                done
);

  localparam int SCNT_W = (LENGTH > 1)   ? $clog2(LENGTH)   : 1;
  localparam int DCNT_W = (POOL_LAT > 1) ? $clog2(POOL_LAT) : 1;

  pool_state_t       state;
  logic [CNT_W-1:0]  win_target;
  logic [CNT_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  win_next;
  logic [SCNT_W-1:0] smp_cnt;
  logic [DCNT_W-1:0] drn_cnt;
  logic              accept;

  assign in_ready  = (state == ST_LOAD);
  assign accept    = in_ready && in_valid;
  assign pool_ena  = accept || (state == ST_DRAIN);
  // Drain beats push zeros, which never win an unsigned max.
  assign pool_data = (state == ST_LOAD) ? in_data : '0;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);
  assign win_next  = win_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      win_target <= '0;
      win_cnt    <= '0;
      smp_cnt    <= '0;
      drn_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            win_target <= num_windows;
            win_cnt    <= '0;
            smp_cnt    <= '0;
            drn_cnt    <= '0;
            state      <= (num_windows == '0) ? ST_FIN : ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            if (smp_cnt == SCNT_W'(LENGTH - 1)) begin
              smp_cnt <= '0;
              drn_cnt <= '0;
              state   <= ST_DRAIN;
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (drn_cnt == DCNT_W'(POOL_LAT - 1)) begin
            drn_cnt <= '0;
            state   <= ST_OUT;
          end else begin
            drn_cnt <= drn_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          // First OUT cycle captures the settled datapath result.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= pool_result;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            win_cnt   <= win_next;
            state     <= (win_next == win_target) ? ST_FIN : ST_LOAD;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
